// File: rtl/clkbuf_ctrl_pkg.sv
// Shared types and defaults for the clock-buffer enable sequencer.
package clkbuf_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_WAKE   = 2'd1,
    ST_ON     = 2'd2,
    ST_LINGER = 2'd3
  } clkbuf_state_e;

  localparam int unsigned DEF_N           = 4;
  localparam int unsigned DEF_WAKE_CYCLES = 4;
  localparam int unsigned DEF_IDLE_CYCLES = 8;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clkbuf_enable_ctrl_if.sv
// Request/grant bundle between clock consumers and the buffer sequencer.
interface clkbuf_enable_ctrl_if #(
  parameter int unsigned N = 4
);
  logic [N-1:0] req;
  logic         force_on;
  logic [N-1:0] ack;
  logic         buf_en;
  logic         clk_active;
  logic [1:0]   state_o;

  modport master (output req, force_on, input ack, buf_en, clk_active, state_o);
  modport slave  (input req, force_on, output ack, buf_en, clk_active, state_o);
endinterface

// File: rtl/clkbuf_dn_counter.sv
// Loadable down-counter that stops at zero; clear forces it back to idle.
module clkbuf_dn_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  input  logic         i_clr,
  output logic         o_zero_c
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/clkbuf_enable_ctrl.sv
// Clock-buffer sequencer: warm-up before grant, idle linger before shutdown.
module clkbuf_enable_ctrl
  import clkbuf_ctrl_pkg::*;
#(
  parameter int unsigned N           = DEF_N,
  parameter int unsigned WAKE_CYCLES = DEF_WAKE_CYCLES,
  parameter int unsigned IDLE_CYCLES = DEF_IDLE_CYCLES
) (
  input  logic                 master_clk,
  input  logic                 rst_n,
  clkbuf_enable_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(max_u(WAKE_CYCLES, IDLE_CYCLES)) + 1;

  clkbuf_state_e r_state;
  logic [N-1:0]  r_ack;
  logic          r_buf_en;
  logic          r_clk_active;

  logic w_any_req;
  logic w_wake_load, w_wake_dec, w_wake_zero;
  logic w_idle_load, w_idle_dec, w_idle_clr, w_idle_zero;

  assign w_any_req = (|bus.req) | bus.force_on;

  // Counter controls derived from the current state and this edge's request.
  always_comb begin
    w_wake_load = 1'b0;
    w_wake_dec  = 1'b0;
    w_idle_load = 1'b0;
    w_idle_dec  = 1'b0;
    w_idle_clr  = 1'b0;
    unique case (r_state)
      ST_OFF:    w_wake_load = w_any_req;
      ST_WAKE: begin
        w_wake_dec  = !w_wake_zero;
        w_idle_load = w_wake_zero && !w_any_req;
      end
      ST_ON:     w_idle_load = !w_any_req;
      ST_LINGER: begin
        w_idle_clr = w_any_req;
        w_idle_dec = !w_any_req;
      end
      default: ;
    endcase
  end

  clkbuf_dn_counter #(.W(CNT_W)) u_wake_cnt (
    .clk        (master_clk),
    .rst_n      (rst_n),
    .i_load     (w_wake_load),
    .i_load_val (CNT_W'(WAKE_CYCLES - 1)),
    .i_dec      (w_wake_dec),
    .i_clr      (1'b0),
    .o_zero_c   (w_wake_zero)
  );

  clkbuf_dn_counter #(.W(CNT_W)) u_idle_cnt (
    .clk        (master_clk),
    .rst_n      (rst_n),
    .i_load     (w_idle_load),
    .i_load_val (CNT_W'(IDLE_CYCLES - 1)),
    .i_dec      (w_idle_dec),
    .i_clr      (w_idle_clr),
    .o_zero_c   (w_idle_zero)
  );

  // WAKE always runs to completion; a request at linger expiry beats shutdown.
  always_ff @(posedge master_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_OFF;
      r_ack        <= '0;
      r_buf_en     <= 1'b0;
      r_clk_active <= 1'b0;
    end else begin
      unique case (r_state)
        ST_OFF: begin
          if (w_any_req) begin
            r_state  <= ST_WAKE;
            r_buf_en <= 1'b1;
          end
        end
        ST_WAKE: begin
          if (w_wake_zero) begin
            if (w_any_req) begin
              r_state      <= ST_ON;
              r_clk_active <= 1'b1;
              r_ack        <= bus.req;
            end else begin
              r_state <= ST_LINGER;
            end
          end
        end
        ST_ON: begin
          if (w_any_req) begin
            r_ack <= bus.req;
          end else begin
            r_state      <= ST_LINGER;
            r_clk_active <= 1'b0;
            r_ack        <= '0;
          end
        end
        ST_LINGER: begin
          if (w_any_req) begin
            r_state      <= ST_ON;
            r_clk_active <= 1'b1;
            r_ack        <= bus.req;
          end else if (w_idle_zero) begin
            r_state  <= ST_OFF;
            r_buf_en <= 1'b0;
          end
        end
        default: r_state <= ST_OFF;
      endcase
    end
  end

  assign bus.ack        = r_ack;
  assign bus.buf_en     = r_buf_en;
  assign bus.clk_active = r_clk_active;
  assign bus.state_o    = r_state;

endmodule

// File: tb/tb_clkbuf_enable_ctrl.sv
// Directed bench for clkbuf_enable_ctrl with N=4, WAKE_CYCLES=4, IDLE_CYCLES=8.
module tb_clkbuf_enable_ctrl;

  localparam int unsigned ST_OFF = 0, ST_WAKE = 1, ST_ON = 2, ST_LINGER = 3;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  clkbuf_enable_ctrl_if #(.N(4)) bus ();

  clkbuf_enable_ctrl #(.N(4), .WAKE_CYCLES(4), .IDLE_CYCLES(8)) dut (
    .master_clk (clk),
    .rst_n      (rst_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge, sample 1ns later, and check the output ordering invariant.
  task automatic tick();
    logic ok;
    @(posedge clk);
    #1;
    ok = ((bus.ack == 4'b0) || bus.clk_active) && (!bus.clk_active || bus.buf_en);
    chk("invariant", 32'(ok), 32'd1);
  endtask

  task automatic expect_st(input string tag, input int unsigned st, input logic [3:0] ack,
                           input logic en, input logic act);
    chk({tag, ".state"}, 32'(bus.state_o), 32'(st));
    chk({tag, ".ack"}, 32'(bus.ack), 32'(ack));
    chk({tag, ".buf_en"}, 32'(bus.buf_en), 32'(en));
    chk({tag, ".clk_active"}, 32'(bus.clk_active), 32'(act));
  endtask

  // Idle linger from its entry edge: seven more edges with buffer on, then OFF.
  task automatic linger_to_off(input string tag);
    for (int i = 0; i < 7; i++) begin
      tick();
      expect_st({tag, ".linger"}, ST_LINGER, 4'b0, 1'b1, 1'b0);
    end
    tick();
    expect_st({tag, ".off"}, ST_OFF, 4'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_vec       = 0;
    n_miss      = 0;
    rst_n       = 1'b0;
    bus.req     = 4'b0001;
    bus.force_on = 1'b0;

    // 1: reset with req[0] held, then warm-up into ON
    repeat (3) @(posedge clk);
    #1;
    expect_st("t1.reset", ST_OFF, 4'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    expect_st("t1.wake_entry", ST_WAKE, 4'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_st("t1.wake", ST_WAKE, 4'b0, 1'b1, 1'b0);
    end
    tick();
    expect_st("t1.on", ST_ON, 4'b0001, 1'b1, 1'b1);

    // 2: drop the only request, linger then shut off
    bus.req = 4'b0000;
    tick();
    expect_st("t2.linger_entry", ST_LINGER, 4'b0, 1'b1, 1'b0);
    linger_to_off("t2");

    // 3: re-request during linger returns to ON without warm-up
    bus.req = 4'b0001;
    repeat (5) tick();
    expect_st("t3.on", ST_ON, 4'b0001, 1'b1, 1'b1);
    bus.req = 4'b0000;
    repeat (4) tick();
    expect_st("t3.linger3", ST_LINGER, 4'b0, 1'b1, 1'b0);
    bus.req = 4'b0100;
    tick();
    expect_st("t3.reon", ST_ON, 4'b0100, 1'b1, 1'b1);

    // 3b: request arriving on the expiry edge keeps the buffer on
    bus.req = 4'b0000;
    repeat (8) tick();
    expect_st("t3b.last_linger", ST_LINGER, 4'b0, 1'b1, 1'b0);
    bus.req = 4'b1000;
    tick();
    expect_st("t3b.expiry_req", ST_ON, 4'b1000, 1'b1, 1'b1);
    bus.req = 4'b0000;
    tick();
    linger_to_off("t3b");

    // 4: short pulse in OFF runs a full warm-up then lingers with no ack
    bus.req = 4'b0010;
    tick();
    expect_st("t4.wake0", ST_WAKE, 4'b0, 1'b1, 1'b0);
    tick();
    bus.req = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      tick();
      expect_st("t4.wake", ST_WAKE, 4'b0, 1'b1, 1'b0);
    end
    tick();
    expect_st("t4.linger_entry", ST_LINGER, 4'b0, 1'b1, 1'b0);
    linger_to_off("t4");

    // 5: force_on alone holds ON without ack; async reset drops everything
    bus.force_on = 1'b1;
    repeat (5) tick();
    expect_st("t5.on", ST_ON, 4'b0, 1'b1, 1'b1);
    repeat (3) tick();
    expect_st("t5.hold", ST_ON, 4'b0, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    expect_st("t5.async_rst", ST_OFF, 4'b0, 1'b0, 1'b0);
    bus.force_on = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    expect_st("t5.idle", ST_OFF, 4'b0, 1'b0, 1'b0);

    // 6: staggered requesters tracked independently while staying ON
    bus.req = 4'b0001;
    repeat (5) tick();
    expect_st("t6.t0", ST_ON, 4'b0001, 1'b1, 1'b1);
    for (int i = 1; i < 10; i++) begin
      tick();
      expect_st("t6.hold0", ST_ON, 4'b0001, 1'b1, 1'b1);
    end
    bus.req = 4'b1001;
    tick();
    expect_st("t6.ack3_rise", ST_ON, 4'b1001, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_st("t6.hold03", ST_ON, 4'b1001, 1'b1, 1'b1);
    end
    bus.req = 4'b1000;
    tick();
    expect_st("t6.ack0_fall", ST_ON, 4'b1000, 1'b1, 1'b1);
    bus.req = 4'b0110;
    tick();
    expect_st("t6.swap", ST_ON, 4'b0110, 1'b1, 1'b1);
    bus.req = 4'b0000;
    tick();
    expect_st("t6.linger", ST_LINGER, 4'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
